// File: rtl/axi_ram_slave_if.sv
// AXI3 bus bundle between the CPU master and the RAM responder.
// Clock and reset stay outside the bundle as plain ports.
interface axi_ram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI3 responder backed by a word-addressed RAM; independent read and write
// channels, one outstanding transaction each, FIXED/INCR bursts of 1-16 beats.
module axi_ram_slave #(
    parameter int MEM_AW   = 16,
    parameter int RD_DELAY = 1
) (
    input  logic           aclk,
    input  logic           aresetn,
    axi_ram_slave_if.slave bus
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    // NOTE: the RAM array is deliberately left out of reset so it maps onto block RAM and survives a bus reset.
    logic [31:0] mem [0:(2**MEM_AW)-1];

    // WRAP and the reserved encoding, or beats wider than the 32-bit bus, are rejected.
    function automatic logic bad_burst(input logic [1:0] burst, input logic [2:0] size);
        return burst[1] || (size > 3'd2);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst,
                                              input logic [2:0] size);
        return (burst == BURST_INCR) ? addr + (32'd1 << size) : addr;
    endfunction

    // ---------------- read channel ----------------
    r_state_e    r_state, r_next;
    logic [3:0]  ar_id_q, ar_len_q, r_beat_q, r_dly_q;
    logic [31:0] ar_addr_q;
    logic [2:0]  ar_size_q;
    logic [1:0]  ar_burst_q;
    logic        ar_err_q;
    logic        r_hs, r_fill, f_err, f_last;
    logic [31:0] f_addr;
    logic [3:0]  f_id;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    // r_fill marks the edges where the R output registers load the next beat.
    always_comb begin
        r_next      = r_state;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        r_hs        = 1'b0;
        r_fill      = 1'b0;
        f_addr      = ar_addr_q;
        f_id        = ar_id_q;
        f_err       = ar_err_q;
        f_last      = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                bus.arready = 1'b1;
                f_addr      = bus.araddr;
                f_id        = bus.arid;
                f_err       = bad_burst(bus.arburst, bus.arsize);
                f_last      = (bus.arlen == 4'd0);
                if (bus.arvalid) begin
                    r_next = (RD_DELAY == 0) ? R_BURST : R_WAIT;
                    r_fill = (RD_DELAY == 0);
                end
            end
            R_WAIT: begin
                f_last = (ar_len_q == 4'd0);
                if (r_dly_q == 4'(RD_DELAY - 1)) begin
                    r_next = R_BURST;
                    r_fill = 1'b1;
                end
            end
            R_BURST: begin
                bus.rvalid = 1'b1;
                r_hs       = bus.rready;
                f_addr     = next_addr(ar_addr_q, ar_burst_q, ar_size_q);
                f_last     = (r_beat_q + 4'd1 == ar_len_q);
                if (bus.rready) begin
                    if (bus.rlast) r_next = R_IDLE;
                    else           r_fill = 1'b1;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            ar_err_q   <= 1'b0;
            r_beat_q   <= '0;
            r_dly_q    <= '0;
            bus.rid    <= '0;
            bus.rdata  <= '0;
            bus.rresp  <= RESP_OKAY;
            bus.rlast  <= 1'b0;
        end else begin
            if (r_state == R_IDLE && bus.arvalid) begin
                ar_id_q    <= bus.arid;
                ar_addr_q  <= bus.araddr;
                ar_len_q   <= bus.arlen;
                ar_size_q  <= bus.arsize;
                ar_burst_q <= bus.arburst;
                ar_err_q   <= f_err;
                r_beat_q   <= '0;
                r_dly_q    <= '0;
            end else if (r_state == R_WAIT) begin
                r_dly_q <= r_dly_q + 4'd1;
            end else if (r_hs && !bus.rlast) begin
                ar_addr_q <= f_addr;
                r_beat_q  <= r_beat_q + 4'd1;
            end
            if (r_fill) begin
                bus.rid   <= f_id;
                bus.rresp <= f_err ? RESP_SLVERR : RESP_OKAY;
                bus.rdata <= f_err ? 32'd0 : mem[f_addr[MEM_AW+1:2]];
                bus.rlast <= f_last;
            end
        end
    end

    // ---------------- write channel ----------------
    w_state_e    w_state, w_next;
    logic [3:0]  aw_id_q, aw_len_q, w_beat_q;
    logic [31:0] aw_addr_q;
    logic [2:0]  aw_size_q;
    logic [1:0]  aw_burst_q;
    logic        aw_bad_q, w_err_q;
    logic        w_hs, w_final, w_beat_err;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    // Bursts end on the beat count; a misplaced wlast only flags the response.
    always_comb begin
        w_next      = w_state;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bid     = '0;
        bus.bresp   = RESP_OKAY;
        w_hs        = 1'b0;
        w_final     = (w_beat_q == aw_len_q);
        w_beat_err  = (bus.wlast != w_final) || (bus.wid != aw_id_q);
        unique case (w_state)
            W_IDLE: begin
                bus.awready = 1'b1;
                if (bus.awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                bus.wready = 1'b1;
                w_hs       = bus.wvalid;
                if (bus.wvalid && w_final) w_next = W_RESP;
            end
            W_RESP: begin
                bus.bvalid = 1'b1;
                bus.bid    = aw_id_q;
                bus.bresp  = w_err_q ? RESP_SLVERR : RESP_OKAY;
                if (bus.bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            aw_bad_q   <= 1'b0;
            w_err_q    <= 1'b0;
            w_beat_q   <= '0;
        end else if (w_state == W_IDLE && bus.awvalid) begin
            aw_id_q    <= bus.awid;
            aw_addr_q  <= bus.awaddr;
            aw_len_q   <= bus.awlen;
            aw_size_q  <= bus.awsize;
            aw_burst_q <= bus.awburst;
            aw_bad_q   <= bad_burst(bus.awburst, bus.awsize);
            w_err_q    <= bad_burst(bus.awburst, bus.awsize);
            w_beat_q   <= '0;
        end else if (w_hs) begin
            w_err_q   <= w_err_q | w_beat_err;
            w_beat_q  <= w_beat_q + 4'd1;
            aw_addr_q <= next_addr(aw_addr_q, aw_burst_q, aw_size_q);
        end
    end

    always_ff @(posedge aclk) begin
        if (w_hs && !aw_bad_q) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) mem[aw_addr_q[MEM_AW+1:2]][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    // Sideband fields and address bits outside the RAM window are intentionally dropped.
    logic unused_bits;
    assign unused_bits = ^{bus.arlock, bus.arcache, bus.arprot, bus.awlock, bus.awcache,
                           bus.awprot, f_addr[1:0], f_addr[31:MEM_AW+2], aw_addr_q[1:0],
                           aw_addr_q[31:MEM_AW+2]};
endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: one task per scenario, expected values
// computed by hand from the behaviour description.
module tb_axi_ram_slave;
    logic aclk;
    logic aresetn;
    int   n_checks;
    int   n_fail;

    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id   [16];
    int          rd_n;
    int          rd_lat;

    axi_ram_slave_if bus ();

    axi_ram_slave #(.MEM_AW(16), .RD_DELAY(1)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus.slave)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic init_bus();
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
    endtask

    // All stimulus tasks start and end just after a falling edge.
    task automatic aw_req(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, output bit ok);
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size;
        bus.awburst = burst; bus.awvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (bus.awready) begin ok = 1'b1; break; end
            @(negedge aclk);
        end
        @(negedge aclk);
        bus.awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last,
                          input logic [3:0] id, output bit ok);
        bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wid = id; bus.wvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (bus.wready) begin ok = 1'b1; break; end
            @(negedge aclk);
        end
        @(negedge aclk);
        bus.wvalid = 1'b0;
    endtask

    task automatic b_get(output logic [1:0] resp, output logic [3:0] id, output bit ok);
        resp = 'x; id = 'x; ok = 1'b0;
        bus.bready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (bus.bvalid) begin ok = 1'b1; resp = bus.bresp; id = bus.bid; break; end
            @(negedge aclk);
        end
        @(negedge aclk);
        bus.bready = 1'b0;
    endtask

    task automatic write_single(input logic [3:0] id, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] strb,
                                output logic [1:0] resp, output logic [3:0] bid, output bit ok);
        bit ok_aw, ok_w, ok_b;
        aw_req(id, addr, 4'd0, 3'd2, 2'b01, ok_aw);
        w_beat(data, strb, 1'b1, id, ok_w);
        b_get(resp, bid, ok_b);
        ok = ok_aw && ok_w && ok_b;
    endtask

    task automatic ar_req(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, output bit ok);
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size;
        bus.arburst = burst; bus.arvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (bus.arready) begin ok = 1'b1; break; end
            @(negedge aclk);
        end
        @(negedge aclk);
        bus.arvalid = 1'b0;
    endtask

    // Collects beats with rready held high; rd_lat counts cycles from the AR handshake cycle.
    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        bit ok;
        rd_n = 0; rd_lat = -1;
        bus.rready = 1'b1;
        ar_req(id, addr, len, size, burst, ok);
        if (ok) begin
            for (int c = 0; c < 100; c++) begin
                if (c > 0) @(negedge aclk);
                if (bus.rvalid) begin
                    if (rd_lat < 0) rd_lat = c + 1;
                    rd_data[rd_n] = bus.rdata; rd_resp[rd_n] = bus.rresp;
                    rd_last[rd_n] = bus.rlast; rd_id[rd_n]   = bus.rid;
                    rd_n++;
                    if (bus.rlast || rd_n == 16) begin @(negedge aclk); break; end
                end
            end
        end
        bus.rready = 1'b0;
    endtask

    task automatic test_reset();
        init_bus();
        aresetn = 1'b1;
        #2 aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        n_checks++; if (bus.arready !== 1'b1) begin n_fail++; $display("FAIL reset_arready: got %b want 1", bus.arready); end
        n_checks++; if (bus.awready !== 1'b1) begin n_fail++; $display("FAIL reset_awready: got %b want 1", bus.awready); end
        n_checks++; if ({bus.rvalid, bus.rlast, bus.wready, bus.bvalid} !== 4'b0000) begin n_fail++; $display("FAIL reset_valids: got %b want 0000", {bus.rvalid, bus.rlast, bus.wready, bus.bvalid}); end
        n_checks++; if ({bus.rid, bus.rdata, bus.rresp} !== 38'd0) begin n_fail++; $display("FAIL reset_rchan: got %h want 0", {bus.rid, bus.rdata, bus.rresp}); end
        n_checks++; if ({bus.bid, bus.bresp} !== 6'd0) begin n_fail++; $display("FAIL reset_bchan: got %h want 0", {bus.bid, bus.bresp}); end
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_single();
        logic [1:0] resp; logic [3:0] bid; bit ok;
        write_single(4'd3, 32'h100, 32'hDEADBEEF, 4'hF, resp, bid, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_wr_handshake: got %b want 1", ok); end
        n_checks++; if (resp !== 2'b00) begin n_fail++; $display("FAIL single_bresp: got %b want 00", resp); end
        n_checks++; if (bid !== 4'd3) begin n_fail++; $display("FAIL single_bid: got %0d want 3", bid); end
        read_burst(4'd3, 32'h100, 4'd0, 3'd2, 2'b01);
        n_checks++; if (rd_n !== 1) begin n_fail++; $display("FAIL single_rd_beats: got %0d want 1", rd_n); end
        n_checks++; if (rd_lat !== 2) begin n_fail++; $display("FAIL single_rd_latency: got %0d want 2", rd_lat); end
        n_checks++; if (rd_data[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rdata: got %h want deadbeef", rd_data[0]); end
        n_checks++; if ({rd_id[0], rd_last[0], rd_resp[0]} !== {4'd3, 1'b1, 2'b00}) begin n_fail++; $display("FAIL single_rid_rlast_rresp: got %h want %h", {rd_id[0], rd_last[0], rd_resp[0]}, {4'd3, 1'b1, 2'b00}); end
    endtask

    task automatic test_incr();
        logic [1:0] resp; logic [3:0] bid; bit ok, ok_w;
        logic [31:0] exp [6];
        exp = '{32'hA, 32'hB, 32'd1, 32'd2, 32'd3, 32'd4};
        write_single(4'd0, 32'h1F8, 32'hA, 4'hF, resp, bid, ok);
        write_single(4'd0, 32'h1FC, 32'hB, 4'hF, resp, bid, ok);
        aw_req(4'd5, 32'h200, 4'd3, 3'd2, 2'b01, ok);
        for (int i = 0; i < 4; i++) begin
            w_beat(32'(i + 1), 4'hF, i == 3, 4'd5, ok_w);
            ok = ok && ok_w;
        end
        b_get(resp, bid, ok_w);
        n_checks++; if ({ok, ok_w, resp, bid} !== {1'b1, 1'b1, 2'b00, 4'd5}) begin n_fail++; $display("FAIL incr_wr_b: got %h want %h", {ok, ok_w, resp, bid}, {1'b1, 1'b1, 2'b00, 4'd5}); end
        read_burst(4'd1, 32'h1F8, 4'd5, 3'd2, 2'b01);
        n_checks++; if (rd_n !== 6) begin n_fail++; $display("FAIL incr_rd_beats: got %0d want 6", rd_n); end
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (rd_data[i] !== exp[i]) begin n_fail++; $display("FAIL incr_rdata[%0d]: got %h want %h", i, rd_data[i], exp[i]); end
            n_checks++; if ({rd_last[i], rd_resp[i], rd_id[i]} !== {i == 5, 2'b00, 4'd1}) begin n_fail++; $display("FAIL incr_ctl[%0d]: got %h want %h", i, {rd_last[i], rd_resp[i], rd_id[i]}, {i == 5, 2'b00, 4'd1}); end
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp; logic [3:0] bid; bit ok;
        write_single(4'd2, 32'h300, 32'hAAAAAAAA, 4'hF, resp, bid, ok);
        write_single(4'd2, 32'h300, 32'h11223344, 4'b0101, resp, bid, ok);
        read_burst(4'd2, 32'h300, 4'd0, 3'd2, 2'b01);
        n_checks++; if (rd_data[0] !== 32'hAA22AA44) begin n_fail++; $display("FAIL strobe_rdata: got %h want aa22aa44", rd_data[0]); end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp; logic [3:0] bid; bit ok;
        logic [31:0] got [4];
        logic        lst [4];
        int nb, stall;
        nb = 0; stall = 0;
        bus.rready = 1'b1;
        ar_req(4'd4, 32'h200, 4'd3, 3'd2, 2'b01, ok);
        for (int c = 0; c < 100 && ok; c++) begin
            if (c > 0) @(negedge aclk);
            if (bus.rvalid) begin
                if (nb == 1 && stall < 3) begin
                    bus.rready = 1'b0;
                    stall++;
                    n_checks++; if ({bus.rdata, bus.rlast} !== {32'd2, 1'b0}) begin n_fail++; $display("FAIL bp_r_stable[%0d]: got %h want %h", stall, {bus.rdata, bus.rlast}, {32'd2, 1'b0}); end
                end else begin
                    bus.rready = 1'b1;
                    got[nb] = bus.rdata; lst[nb] = bus.rlast;
                    nb++;
                    if (bus.rlast || nb == 4) begin @(negedge aclk); break; end
                end
            end
        end
        bus.rready = 1'b0;
        n_checks++; if (nb !== 4 || stall !== 3) begin n_fail++; $display("FAIL bp_r_beats: got %0d/%0d want 4/3", nb, stall); end
        for (int i = 0; i < nb; i++) begin
            n_checks++; if ({got[i], lst[i]} !== {32'(i + 1), i == 3}) begin n_fail++; $display("FAIL bp_r_beat[%0d]: got %h want %h", i, {got[i], lst[i]}, {32'(i + 1), i == 3}); end
        end
        aw_req(4'd6, 32'h304, 4'd0, 3'd2, 2'b01, ok);
        w_beat(32'h12345678, 4'hF, 1'b1, 4'd6, ok);
        bus.awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if ({bus.bvalid, bus.awready} !== 2'b10) begin n_fail++; $display("FAIL bp_b_hold[%0d]: got %b want 10", i, {bus.bvalid, bus.awready}); end
            @(negedge aclk);
        end
        bus.awvalid = 1'b0;
        b_get(resp, bid, ok);
        n_checks++; if ({ok, resp, bid} !== {1'b1, 2'b00, 4'd6}) begin n_fail++; $display("FAIL bp_b_resp: got %h want %h", {ok, resp, bid}, {1'b1, 2'b00, 4'd6}); end
    endtask

    task automatic test_fixed();
        read_burst(4'd2, 32'h100, 4'd3, 3'd2, 2'b00);
        n_checks++; if (rd_n !== 4) begin n_fail++; $display("FAIL fixed_beats: got %0d want 4", rd_n); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if ({rd_data[i], rd_last[i], rd_resp[i]} !== {32'hDEADBEEF, i == 3, 2'b00}) begin n_fail++; $display("FAIL fixed_beat[%0d]: got %h want %h", i, {rd_data[i], rd_last[i], rd_resp[i]}, {32'hDEADBEEF, i == 3, 2'b00}); end
        end
    endtask

    task automatic test_errors();
        logic [1:0] resp; logic [3:0] bid; bit ok;
        read_burst(4'd4, 32'h100, 4'd3, 3'd2, 2'b10);
        n_checks++; if (rd_n !== 4) begin n_fail++; $display("FAIL wrap_beats: got %0d want 4", rd_n); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if ({rd_data[i], rd_last[i], rd_resp[i]} !== {32'd0, i == 3, 2'b10}) begin n_fail++; $display("FAIL wrap_beat[%0d]: got %h want %h", i, {rd_data[i], rd_last[i], rd_resp[i]}, {32'd0, i == 3, 2'b10}); end
        end
        read_burst(4'd4, 32'h100, 4'd0, 3'd3, 2'b01);
        n_checks++; if ({rd_n[4:0], rd_data[0], rd_resp[0]} !== {5'd1, 32'd0, 2'b10}) begin n_fail++; $display("FAIL size_err: got %h want %h", {rd_n[4:0], rd_data[0], rd_resp[0]}, {5'd1, 32'd0, 2'b10}); end
        // A WRAP write must be refused and leave the word untouched.
        aw_req(4'd9, 32'h100, 4'd0, 3'd2, 2'b10, ok);
        w_beat(32'h0, 4'hF, 1'b1, 4'd9, ok);
        b_get(resp, bid, ok);
        n_checks++; if ({ok, resp, bid} !== {1'b1, 2'b10, 4'd9}) begin n_fail++; $display("FAIL wrap_wr_bresp: got %h want %h", {ok, resp, bid}, {1'b1, 2'b10, 4'd9}); end
        read_burst(4'd0, 32'h100, 4'd0, 3'd2, 2'b01);
        n_checks++; if (rd_data[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wrap_wr_suppressed: got %h want deadbeef", rd_data[0]); end
        aw_req(4'd7, 32'h400, 4'd3, 3'd2, 2'b01, ok);
        for (int i = 0; i < 4; i++) w_beat(32'(i), 4'hF, (i == 1) || (i == 3), 4'd7, ok);
        b_get(resp, bid, ok);
        n_checks++; if ({ok, resp, bid} !== {1'b1, 2'b10, 4'd7}) begin n_fail++; $display("FAIL early_wlast_bresp: got %h want %h", {ok, resp, bid}, {1'b1, 2'b10, 4'd7}); end
        aw_req(4'd8, 32'h404, 4'd0, 3'd2, 2'b01, ok);
        w_beat(32'h1, 4'hF, 1'b1, 4'd9, ok);
        b_get(resp, bid, ok);
        n_checks++; if ({ok, resp, bid} !== {1'b1, 2'b10, 4'd8}) begin n_fail++; $display("FAIL wid_mismatch_bresp: got %h want %h", {ok, resp, bid}, {1'b1, 2'b10, 4'd8}); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int seen;
        seen = 0;
        aw_req(4'd1, 32'h500, 4'd3, 3'd2, 2'b01, ok);
        w_beat(32'h55, 4'hF, 1'b0, 4'd1, ok);
        bus.rready = 1'b1;
        ar_req(4'd2, 32'h200, 4'd3, 3'd2, 2'b01, ok);
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge aclk);
            if (bus.rvalid) begin
                seen++;
                if (seen == 2) begin bus.rready = 1'b0; break; end
            end
        end
        n_checks++; if ({bus.rvalid, bus.wready, bus.rdata} !== {1'b1, 1'b1, 32'd2}) begin n_fail++; $display("FAIL mid_pre_reset: got %h want %h", {bus.rvalid, bus.wready, bus.rdata}, {1'b1, 1'b1, 32'd2}); end
        #1 aresetn = 1'b0;
        #1;
        n_checks++; if ({bus.rvalid, bus.wready} !== 2'b00) begin n_fail++; $display("FAIL mid_reset_async: got %b want 00", {bus.rvalid, bus.wready}); end
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        n_checks++; if ({bus.arready, bus.awready, bus.rvalid, bus.bvalid} !== 4'b1100) begin n_fail++; $display("FAIL mid_post_release: got %b want 1100", {bus.arready, bus.awready, bus.rvalid, bus.bvalid}); end
        read_burst(4'd3, 32'h100, 4'd0, 3'd2, 2'b01);
        n_checks++; if ({rd_n[4:0], rd_data[0]} !== {5'd1, 32'hDEADBEEF}) begin n_fail++; $display("FAIL mid_ram_kept: got %h want %h", {rd_n[4:0], rd_data[0]}, {5'd1, 32'hDEADBEEF}); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_incr();
        test_strobe();
        test_backpressure();
        test_fixed();
        test_errors();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
